// File: rtl/bram_pkg.sv
// Shared types and widths for the ram3 backup SRAM arbiter (bram_arb).
package bram_pkg;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;
    typedef enum logic {OWN_CPU = 1'b0, OWN_MCU = 1'b1} owner_t;
endpackage

// File: rtl/bram_arb_pick.sv
// Combinational grant selector: fixed CPU priority, with one MCU grant forced
// once the CPU has won CPU_BURST_MAX times in a row while the MCU was waiting.
module bram_arb_pick
    import bram_pkg::*;
#(
    parameter int CPU_BURST_MAX = 8
)(
    input  logic       cpu_req,
    input  logic       mcu_req,
    input  logic [7:0] burst_cnt,
    output logic       grant,
    output logic       owner
);
    always_comb begin
        grant = cpu_req | mcu_req;
        owner = OWN_CPU;
        if (mcu_req && (!cpu_req || burst_cnt == 8'(CPU_BURST_MAX))) begin
            owner = OWN_MCU;
        end
    end
endmodule

// File: rtl/bram_arb.sv
// Two-port arbiter and timing sequencer for the ram3 backup SRAM.
// Optional macro BRAM_WPROT_EN adds a wprot input that suppresses CPU writes.
module bram_arb
    import bram_pkg::*;
#(
    parameter int ACC_CYC       = 4,
    parameter int CPU_BURST_MAX = 8
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              mcu_req,
    input  logic              mcu_we,
    input  logic [1:0]        mcu_be,
    input  logic [ADDR_W-1:0] mcu_addr,
    input  logic [DATA_W-1:0] mcu_wdata,
    output logic [DATA_W-1:0] mcu_rdata,
    output logic              mcu_ack,
`ifdef BRAM_WPROT_EN
    input  logic              wprot,
`endif
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dout,
    input  logic [DATA_W-1:0] ram_din,
    output logic              ram_drive,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              ram_ub_n,
    output logic              ram_lb_n,
    output logic              busy
);
    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [3:0]        cyc_q, cyc_d;
    logic [7:0]        burst_q, burst_d;
    logic              we_q, we_d;
    logic              prot_q, prot_d;
    logic [1:0]        be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] mcu_rdata_q, mcu_rdata_d;
    logic              pick_grant, pick_owner;
    logic              grant, grant_mcu, wprot_in, write_en;

`ifdef BRAM_WPROT_EN
    assign wprot_in = wprot;
`else
    assign wprot_in = 1'b0;
`endif

    bram_arb_pick #(.CPU_BURST_MAX(CPU_BURST_MAX)) u_pick (
        .cpu_req   (cpu_req),
        .mcu_req   (mcu_req),
        .burst_cnt (burst_q),
        .grant     (pick_grant),
        .owner     (pick_owner)
    );

    assign grant     = (state_q == IDLE) && pick_grant;
    assign grant_mcu = grant && (owner_t'(pick_owner) == OWN_MCU);
    // A protected write keeps its full timing but never drives or strobes the RAM.
    assign write_en  = we_q && !prot_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            cyc_q       <= '0;
            burst_q     <= '0;
            we_q        <= 1'b0;
            prot_q      <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            mcu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cyc_q       <= cyc_d;
            burst_q     <= burst_d;
            we_q        <= we_d;
            prot_q      <= prot_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            mcu_rdata_q <= mcu_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        prot_d      = prot_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        mcu_rdata_d = mcu_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = SETUP;
                    if (grant_mcu) begin
                        owner_d = OWN_MCU;
                        we_d    = mcu_we;
                        prot_d  = 1'b0;
                        be_d    = mcu_be;
                        addr_d  = mcu_addr;
                        wdata_d = mcu_wdata;
                    end else begin
                        owner_d = OWN_CPU;
                        we_d    = cpu_we;
                        prot_d  = cpu_we && wprot_in;
                        be_d    = cpu_be;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                end
            end
            SETUP: begin
                state_d = STROBE;
                cyc_d   = '0;
            end
            STROBE: begin
                if (cyc_q == 4'(ACC_CYC - 1)) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (owner_q == OWN_MCU) mcu_rdata_d = ram_din;
                        else                    cpu_rdata_d = ram_din;
                    end
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The burst count only tracks CPU wins while the MCU is actually waiting.
    always_comb begin
        burst_d = burst_q;
        if (grant_mcu || !mcu_req) begin
            burst_d = '0;
        end else if (grant) begin
            burst_d = burst_q + 8'd1;
        end
    end

    always_comb begin
        ram_oe_n  = 1'b1;
        ram_we_n  = 1'b1;
        ram_ub_n  = 1'b1;
        ram_lb_n  = 1'b1;
        ram_drive = 1'b0;
        cpu_ack   = 1'b0;
        mcu_ack   = 1'b0;
        unique case (state_q)
            SETUP: begin
                ram_ub_n  = !be_q[1];
                ram_lb_n  = !be_q[0];
                ram_drive = write_en;
            end
            STROBE: begin
                ram_ub_n  = !be_q[1];
                ram_lb_n  = !be_q[0];
                ram_drive = write_en;
                ram_oe_n  = we_q;
                ram_we_n  = !write_en;
            end
            DONE: begin
                ram_drive = write_en;
                cpu_ack   = (owner_q == OWN_CPU);
                mcu_ack   = (owner_q == OWN_MCU);
            end
            default: ;
        endcase
    end

    assign ram_addr  = addr_q;
    assign ram_dout  = wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign mcu_rdata = mcu_rdata_q;
    assign busy      = (state_q != IDLE);
endmodule
